// File: rtl/password_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : password_lock_ctrl
// Desc     : Keypad password lock with runtime code change, failed-attempt
//            lockout, inactivity timeout and per-digit display blanking.
//            Optional macro PWD_MASK_EN shows entered digits as 4'h8.
// Revision : 1.0 - initial release
// ============================================================================
module password_lock_ctrl #(
    parameter int          CODE_LEN       = 4,
    parameter int          NUM_DIGITS     = 4,
    parameter int          MAX_TRIES      = 3,
    parameter int          MSG_CYCLES     = 50_000_000,
    parameter int          LOCKOUT_CYCLES = 500_000_000,
    parameter int          IDLE_CYCLES    = 500_000_000,
    parameter logic [31:0] DEFAULT_CODE   = 32'h0000_1234
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [3:0]                       key_value,
    input  logic                             key_valid,
    output logic [4*NUM_DIGITS-1:0]          display_data,
    output logic [NUM_DIGITS-1:0]            digit_en,
    output logic                             unlocked,
    output logic                             alarm,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
    output logic [2:0]                       state_o
);

    localparam int BUF_W   = 4 * CODE_LEN;
    localparam int CNT_W   = $clog2(CODE_LEN + 1);
    localparam int FAIL_W  = $clog2(MAX_TRIES + 1);
    localparam int LIM_A   = (MSG_CYCLES > LOCKOUT_CYCLES) ? MSG_CYCLES : LOCKOUT_CYCLES;
    localparam int MAX_LIM = (LIM_A > IDLE_CYCLES) ? LIM_A : IDLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_LIM + 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_ENTRY    = 3'd1;
    localparam logic [2:0] c_ST_CHECK    = 3'd2;
    localparam logic [2:0] c_ST_FAIL     = 3'd3;
    localparam logic [2:0] c_ST_UNLOCKED = 3'd4;
    localparam logic [2:0] c_ST_NEW      = 3'd5;
    localparam logic [2:0] c_ST_LOCKOUT  = 3'd6;

    localparam logic [3:0] c_KEY_STAR = 4'hE;
    localparam logic [3:0] c_KEY_HASH = 4'hF;
    localparam logic [3:0] c_KEY_CHG  = 4'hC;

    localparam logic [CNT_W-1:0]  c_CNT_FULL   = CNT_W'(CODE_LEN);
    localparam logic [FAIL_W-1:0] c_FAIL_MAX   = FAIL_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0]  c_MSG_LAST   = TMR_W'(MSG_CYCLES - 1);
    localparam logic [TMR_W-1:0]  c_LOCK_LAST  = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  c_IDLE_LAST  = TMR_W'(IDLE_CYCLES - 1);
    localparam logic [BUF_W-1:0]  c_RESET_CODE = DEFAULT_CODE[BUF_W-1:0];

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [BUF_W-1:0]  r_buf;
    logic [BUF_W-1:0]  w_buf_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [BUF_W-1:0]  r_code;
    logic [BUF_W-1:0]  w_code_nxt;
    logic [FAIL_W-1:0] r_fail;
    logic [FAIL_W-1:0] w_fail_nxt;
    logic [FAIL_W-1:0] w_fail_inc;
    logic [TMR_W-1:0]  r_timer;
    logic [TMR_W-1:0]  w_timer_nxt;

    logic              w_is_digit;
    logic              w_full;
    logic              w_match;
    logic [BUF_W-1:0]  w_buf_shift;
    logic              w_keyed_state;
    logic              w_timed_state;
    logic              w_in_entry;
    logic              w_all_on;
    logic              w_show_e;

    assign w_is_digit  = (key_value <= 4'd9);
    assign w_full      = (r_cnt == c_CNT_FULL);
    assign w_match     = w_full && (r_buf == r_code);
    assign w_buf_shift = (r_buf << 4) | BUF_W'(key_value);
    assign w_fail_inc  = r_fail + FAIL_W'(1);

    // States where a key press restarts the inactivity timer
    assign w_keyed_state = (r_state == c_ST_ENTRY) || (r_state == c_ST_UNLOCKED) ||
                           (r_state == c_ST_NEW);
    assign w_timed_state = w_keyed_state || (r_state == c_ST_FAIL) ||
                           (r_state == c_ST_LOCKOUT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_code  <= c_RESET_CODE;
            r_fail  <= '0;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_buf   <= w_buf_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
            r_fail  <= w_fail_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_buf_nxt   = r_buf;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_fail_nxt  = r_fail;
        case (r_state)
            c_ST_IDLE: begin
                if (key_valid && w_is_digit) begin
                    w_state_nxt = c_ST_ENTRY;
                    w_buf_nxt   = BUF_W'(key_value);
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            c_ST_ENTRY: begin
                // A key, even an ignored one, beats a coincident timeout
                if (key_valid) begin
                    if (w_is_digit) begin
                        if (!w_full) begin
                            w_buf_nxt = w_buf_shift;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else if (key_value == c_KEY_STAR) begin
                        w_state_nxt = c_ST_IDLE;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (key_value == c_KEY_HASH) begin
                        w_state_nxt = c_ST_CHECK;
                    end
                end else if (r_timer == c_IDLE_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_CHECK: begin
                w_buf_nxt = '0;
                w_cnt_nxt = '0;
                if (w_match) begin
                    w_fail_nxt  = '0;
                    w_state_nxt = c_ST_UNLOCKED;
                end else begin
                    w_fail_nxt  = w_fail_inc;
                    w_state_nxt = (w_fail_inc == c_FAIL_MAX) ? c_ST_LOCKOUT : c_ST_FAIL;
                end
            end
            c_ST_FAIL: begin
                if (r_timer == c_MSG_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_LOCKOUT: begin
                if (r_timer == c_LOCK_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_fail_nxt  = '0;
                end
            end
            c_ST_UNLOCKED: begin
                if (key_valid) begin
                    if (key_value == c_KEY_STAR) begin
                        w_state_nxt = c_ST_IDLE;
                    end else if (key_value == c_KEY_CHG) begin
                        w_state_nxt = c_ST_NEW;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end else if (r_timer == c_IDLE_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_NEW: begin
                if (key_valid) begin
                    if (w_is_digit) begin
                        if (!w_full) begin
                            w_buf_nxt = w_buf_shift;
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else if (key_value == c_KEY_HASH && w_full) begin
                        w_code_nxt  = r_buf;
                        w_state_nxt = c_ST_UNLOCKED;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end else if (key_value == c_KEY_STAR) begin
                        w_state_nxt = c_ST_UNLOCKED;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end else if (r_timer == c_IDLE_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_buf_nxt   = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_timer_nxt = '0;
        if ((w_state_nxt == r_state) && w_timed_state && !(key_valid && w_keyed_state)) begin
            w_timer_nxt = r_timer + TMR_W'(1);
        end
    end

    assign w_in_entry = (r_state == c_ST_ENTRY) || (r_state == c_ST_NEW);
    assign w_show_e   = (r_state == c_ST_FAIL) || (r_state == c_ST_LOCKOUT);
    assign w_all_on   = w_show_e || (r_state == c_ST_UNLOCKED);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        logic [3:0] w_entry_nib;
        logic       w_entry_on;

        if (gi < CODE_LEN) begin : g_has_buf
`ifdef PWD_MASK_EN
            assign w_entry_nib = 4'h8;
`else
            assign w_entry_nib = r_buf[4*gi +: 4];
`endif
        end else begin : g_no_buf
            assign w_entry_nib = 4'h0;
        end

        // Newest entry sits at digit 0, so digit gi is live once count > gi
        assign w_entry_on = (int'(r_cnt) > gi);

        assign digit_en[gi] = w_in_entry ? w_entry_on : w_all_on;
        assign display_data[4*gi +: 4] =
            w_in_entry ? (w_entry_on ? w_entry_nib : 4'h0) :
            (w_show_e ? 4'hE : 4'h0);
    end

    assign unlocked = (r_state == c_ST_UNLOCKED) || (r_state == c_ST_NEW);
    assign alarm    = (r_state == c_ST_LOCKOUT);
    assign fail_cnt = r_fail;
    assign state_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_password_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_password_lock_ctrl
// Desc     : Self-checking bench for password_lock_ctrl (short timer limits).
// Revision : 1.0 - initial release
// ============================================================================
module tb_password_lock_ctrl;

    localparam int c_MSG  = 8;
    localparam int c_LOCK = 20;
    localparam int c_IDLE = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  key_value;
    logic        key_valid;
    logic [15:0] display_data;
    logic [3:0]  digit_en;
    logic        unlocked;
    logic        alarm;
    logic [1:0]  fail_cnt;
    logic [2:0]  state_o;

    always #5 clk = ~clk;

    password_lock_ctrl #(
        .CODE_LEN      (4),
        .NUM_DIGITS    (4),
        .MAX_TRIES     (3),
        .MSG_CYCLES    (c_MSG),
        .LOCKOUT_CYCLES(c_LOCK),
        .IDLE_CYCLES   (c_IDLE),
        .DEFAULT_CODE  (32'h0000_1234)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .key_value   (key_value),
        .key_valid   (key_valid),
        .display_data(display_data),
        .digit_en    (digit_en),
        .unlocked    (unlocked),
        .alarm       (alarm),
        .fail_cnt    (fail_cnt),
        .state_o     (state_o)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic        unl;
        logic        alm;
        logic [1:0]  fc;
        logic [3:0]  en;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       kv;
        logic [3:0] key;
        exp_t       e;
    } vec_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [1:0]  m_fc;
    int          m_cnt;
    logic [3:0]  m_en;
    logic [15:0] m_data;
    vec_t        tbl[11];

    function automatic exp_t mk(input logic [2:0] st, input logic unl, input logic alm,
                                input logic [1:0] fc, input logic [3:0] en,
                                input logic [15:0] data);
        exp_t r;
        r.st = st; r.unl = unl; r.alm = alm; r.fc = fc; r.en = en; r.data = data;
        return r;
    endfunction

    function automatic exp_t e_idle();  return mk(3'd0, 1'b0, 1'b0, m_fc, 4'h0, 16'h0000); endfunction
    function automatic exp_t e_check(); return mk(3'd2, 1'b0, 1'b0, m_fc, 4'h0, 16'h0000); endfunction
    function automatic exp_t e_fail();  return mk(3'd3, 1'b0, 1'b0, m_fc, 4'hF, 16'hEEEE); endfunction
    function automatic exp_t e_unl();   return mk(3'd4, 1'b1, 1'b0, m_fc, 4'hF, 16'h0000); endfunction
    function automatic exp_t e_lock();  return mk(3'd6, 1'b0, 1'b1, m_fc, 4'hF, 16'hEEEE); endfunction

    // Entered digits read as 8 when the mask build is selected
    function automatic exp_t masked(input exp_t e);
        exp_t r = e;
`ifdef PWD_MASK_EN
        if (e.st == 3'd1 || e.st == 3'd5)
            for (int i = 0; i < 4; i++)
                if (e.en[i]) r.data[4*i +: 4] = 4'h8;
`endif
        return r;
    endfunction

    task automatic step(input logic rst_i, input logic kv, input logic [3:0] key,
                        input exp_t e, input string name);
        exp_t got;
        exp_t want;
        @(negedge clk);
        reset     = rst_i;
        key_valid = kv;
        key_value = key;
        sb_q.push_back(masked(e));
        @(posedge clk);
        #1;
        reset     = 1'b0;
        key_valid = 1'b0;
        want = sb_q.pop_front();
        got  = {state_o, unlocked, alarm, fail_cnt, digit_en, display_data};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got st=%0d unl=%b alm=%b fc=%0d en=%b data=%h, want st=%0d unl=%b alm=%b fc=%0d en=%b data=%h",
                     name, got.st, got.unl, got.alm, got.fc, got.en, got.data,
                     want.st, want.unl, want.alm, want.fc, want.en, want.data);
        end
    endtask

    task automatic hold(input int n, input exp_t e, input logic kv_en,
                        input logic [3:0] key, input string name);
        for (int i = 0; i < n; i++)
            step(1'b0, kv_en && (i % 2 == 0), key, e, name);
    endtask

    task automatic clear_model();
        m_cnt = 0; m_en = 4'h0; m_data = 16'h0;
    endtask

    task automatic enter(input string digs, input logic [2:0] st);
        logic [3:0] d;
        for (int i = 0; i < digs.len(); i++) begin
            d = 4'(digs.getc(i) - 8'd48);
            if (m_cnt < 4) begin
                m_data = {m_data[11:0], d};
                m_en   = {m_en[2:0], 1'b1};
                m_cnt++;
            end
            step(1'b0, 1'b1, d, mk(st, st == 3'd5, 1'b0, m_fc, m_en, m_data), "digit");
        end
    endtask

    task automatic fail_then_idle();
        step(1'b0, 1'b0, 4'h0, e_fail(), "fail_enter");
        hold(c_MSG - 1, e_fail(), 1'b1, 4'h1, "fail_hold");
        step(1'b0, 1'b0, 4'h0, e_idle(), "fail_exit");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; key_valid = 1'b0; key_value = 4'h0;
        m_fc = 2'd0;

        // Basic unlock with the default code, plus ignored keys
        tbl[0]  = '{1'b1, 1'b0, 4'h0, mk(3'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0000)};
        tbl[1]  = '{1'b0, 1'b1, 4'hA, mk(3'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0000)};
        tbl[2]  = '{1'b0, 1'b1, 4'h1, mk(3'd1, 1'b0, 1'b0, 2'd0, 4'h1, 16'h0001)};
        tbl[3]  = '{1'b0, 1'b1, 4'h2, mk(3'd1, 1'b0, 1'b0, 2'd0, 4'h3, 16'h0012)};
        tbl[4]  = '{1'b0, 1'b1, 4'h3, mk(3'd1, 1'b0, 1'b0, 2'd0, 4'h7, 16'h0123)};
        tbl[5]  = '{1'b0, 1'b1, 4'h4, mk(3'd1, 1'b0, 1'b0, 2'd0, 4'hF, 16'h1234)};
        tbl[6]  = '{1'b0, 1'b1, 4'hF, mk(3'd2, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0000)};
        tbl[7]  = '{1'b0, 1'b1, 4'h9, mk(3'd4, 1'b1, 1'b0, 2'd0, 4'hF, 16'h0000)};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, mk(3'd4, 1'b1, 1'b0, 2'd0, 4'hF, 16'h0000)};
        tbl[9]  = '{1'b0, 1'b1, 4'hE, mk(3'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0000)};
        tbl[10] = '{1'b0, 1'b1, 4'hE, mk(3'd0, 1'b0, 1'b0, 2'd0, 4'h0, 16'h0000)};
        for (int i = 0; i < 11; i++)
            step(tbl[i].rst, tbl[i].kv, tbl[i].key, tbl[i].e, $sformatf("tbl%0d", i));

        // Three wrong attempts: two FAIL messages then LOCKOUT
        for (int a = 1; a <= 3; a++) begin
            clear_model();
            enter("1235", 3'd1);
            step(1'b0, 1'b1, 4'hF, e_check(), "wrong_check");
            m_fc = 2'(a);
            if (a < 3) begin
                fail_then_idle();
            end else begin
                hold(c_LOCK, e_lock(), 1'b1, 4'h1, "lock_hold");
                m_fc = 2'd0;
                step(1'b0, 1'b0, 4'h0, e_idle(), "lock_exit");
            end
        end

        // Short entry fails; extra digit beyond CODE_LEN is ignored
        clear_model();
        enter("123", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "short_check");
        m_fc = 2'd1;
        fail_then_idle();
        clear_model();
        enter("12345", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "long_check");
        m_fc = 2'd0;
        step(1'b0, 1'b0, 4'h0, e_unl(), "long_unlock");

        // Code change to 9876
        step(1'b0, 1'b1, 4'hC, mk(3'd5, 1'b1, 1'b0, m_fc, 4'h0, 16'h0000), "chg_enter");
        clear_model();
        enter("987", 3'd5);
        step(1'b0, 1'b1, 4'hF, mk(3'd5, 1'b1, 1'b0, m_fc, 4'h7, 16'h0987), "chg_short_hash");
        enter("6", 3'd5);
        step(1'b0, 1'b1, 4'hF, e_unl(), "chg_commit");
        step(1'b0, 1'b1, 4'hE, e_idle(), "relock");
        clear_model();
        enter("9876", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "new_check");
        step(1'b0, 1'b0, 4'h0, e_unl(), "new_unlock");
        step(1'b0, 1'b1, 4'hE, e_idle(), "relock2");
        clear_model();
        enter("1234", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "old_check");
        m_fc = 2'd1;
        fail_then_idle();

        // Entry abort, ignored key in ENTRY, inactivity timeout and key-at-expiry
        clear_model();
        enter("4", 3'd1);
        step(1'b0, 1'b1, 4'hC, mk(3'd1, 1'b0, 1'b0, m_fc, 4'h1, 16'h0004), "entry_c_ignored");
        step(1'b0, 1'b1, 4'hE, e_idle(), "entry_star");
        clear_model();
        enter("12", 3'd1);
        hold(c_IDLE - 1, mk(3'd1, 1'b0, 1'b0, m_fc, 4'h3, 16'h0012), 1'b0, 4'h0, "idle_wait");
        step(1'b0, 1'b0, 4'h0, e_idle(), "idle_timeout");
        clear_model();
        enter("12", 3'd1);
        hold(c_IDLE - 1, mk(3'd1, 1'b0, 1'b0, m_fc, 4'h3, 16'h0012), 1'b0, 4'h0, "idle_wait2");
        enter("5", 3'd1);
        hold(c_IDLE - 1, mk(3'd1, 1'b0, 1'b0, m_fc, 4'h7, 16'h0125), 1'b0, 4'h0, "idle_restart");
        step(1'b0, 1'b0, 4'h0, e_idle(), "idle_timeout2");

        // Reset mid-LOCKOUT restores defaults
        clear_model();
        enter("1111", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "lk_check2");
        m_fc = 2'd2;
        fail_then_idle();
        clear_model();
        enter("1111", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "lk_check3");
        m_fc = 2'd3;
        hold(5, e_lock(), 1'b1, 4'hE, "lock_partial");
        m_fc = 2'd0;
        step(1'b1, 1'b0, 4'h0, e_idle(), "reset_in_lockout");

        // Reset mid-NEW_ENTRY after a code change reverts to 1234
        clear_model();
        enter("1234", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "rst_chk");
        step(1'b0, 1'b0, 4'h0, e_unl(), "rst_unl");
        step(1'b0, 1'b1, 4'hC, mk(3'd5, 1'b1, 1'b0, m_fc, 4'h0, 16'h0000), "rst_chg");
        clear_model();
        enter("5555", 3'd5);
        step(1'b0, 1'b1, 4'hF, e_unl(), "rst_commit");
        step(1'b0, 1'b1, 4'hC, mk(3'd5, 1'b1, 1'b0, m_fc, 4'h0, 16'h0000), "rst_chg2");
        clear_model();
        enter("7", 3'd5);
        step(1'b1, 1'b0, 4'h0, e_idle(), "reset_in_new");
        clear_model();
        enter("5555", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "post_rst_old");
        m_fc = 2'd1;
        fail_then_idle();
        clear_model();
        enter("1234", 3'd1);
        step(1'b0, 1'b1, 4'hF, e_check(), "post_rst_def");
        m_fc = 2'd0;
        step(1'b0, 1'b0, 4'h0, e_unl(), "post_rst_unlock");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/password_lock_ctrl.md
Name: password_lock_ctrl

Overview:
Parametrised successor to the fixed 4-digit password FSM. Sits between keypad_scanner (key_value/key_valid) and seven_seg_driver (digit nibbles). Adds configurable code length and display width, runtime code change, a failed-attempt counter with timed lockout, inactivity timeout, and per-digit blanking.

Parameters:
CODE_LEN, 4, code digits (1..8)
NUM_DIGITS, 4, display digits driven (1..8)
MAX_TRIES, 3, consecutive failures that trigger lockout (>=1)
MSG_CYCLES, 50_000_000, FAIL message hold time in clk cycles
LOCKOUT_CYCLES, 500_000_000, lockout duration in clk cycles
IDLE_CYCLES, 500_000_000, inactivity timeout in clk cycles
DEFAULT_CODE, 32'h0000_1234, reset code; low 4*CODE_LEN bits used, one BCD digit per nibble, most-significant digit first

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
key_value  in  4  key code from scanner: 0-9 digits, E='*', F='#', C=change-code, A/B/D ignored
key_valid  in  1  one-cycle strobe per key press
display_data  out  4*NUM_DIGITS  nibble per digit; digit 0 in bits [3:0] is rightmost
digit_en  out  NUM_DIGITS  per-digit enable; 0 = blank
unlocked  out  1  high while in UNLOCKED or NEW_ENTRY
alarm  out  1  high while in LOCKOUT
fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failed attempts
state_o  out  3  encoded state: IDLE=0, ENTRY=1, CHECK=2, FAIL=3, UNLOCKED=4, NEW_ENTRY=5, LOCKOUT=6

Behaviour:
- Reset, taking effect at the clk edge where reset=1: state=IDLE; code=DEFAULT_CODE; entry buffer and count cleared; timer=0; display_data=0, digit_en=0, unlocked=0, alarm=0, fail_cnt=0. Reset during any state, including LOCKOUT, aborts that state immediately.
- Every key_valid is consumed on the edge where it is sampled. State and outputs update at t+1.
- Entry buffer: CODE_LEN nibbles plus a count (0..CODE_LEN). A digit key shifts in at the low end and increments count.
  - When count==CODE_LEN, further digits are ignored; no overwrite.
- IDLE: all digits blank. A digit key loads it with count=1 and moves to ENTRY. All other keys are ignored.
- ENTRY:
  - Digit keys: handled as above.
  - '*': clear buffer, go to IDLE.
  - '#': go to CHECK.
  - C, A, B, D: ignored.
  - IDLE_CYCLES with no key_valid: clear buffer, go to IDLE.
- CHECK: exactly one cycle; keys arriving in this cycle are dropped.
  - Match requires count==CODE_LEN and buffer==code.
  - Match: fail_cnt=0, go to UNLOCKED. unlocked rises 2 cycles after the '#' strobe.
  - Mismatch: fail_cnt+1. If the new fail_cnt equals MAX_TRIES, go to LOCKOUT; otherwise go to FAIL.
  - Buffer is cleared on exit from CHECK.
- FAIL: all digits enabled and showing 4'hE. Keys ignored. After MSG_CYCLES, go to IDLE.
- LOCKOUT: alarm=1; all digits show 4'hE; keys ignored. After LOCKOUT_CYCLES, fail_cnt=0 and go to IDLE.
- UNLOCKED: unlocked=1; all digits show 4'h0.
  - '*': relock, go to IDLE.
  - C: clear buffer, go to NEW_ENTRY.
  - IDLE_CYCLES with no key: go to IDLE.
- NEW_ENTRY: digits are entered as in ENTRY.
  - '#' with count==CODE_LEN: code=buffer, go to UNLOCKED.
  - '#' with count<CODE_LEN: ignored.
  - '*': go to UNLOCKED with the code unchanged.
  - Timeout: go to IDLE with the code unchanged.
- Entry display (ENTRY and NEW_ENTRY):
  - The lowest min(count, NUM_DIGITS) digits show the most recent entries, newest at digit 0.
  - Those digits are enabled; the remaining digits are blank with nibble 0.
  - If CODE_LEN > NUM_DIGITS, only the newest NUM_DIGITS entries are shown.
- Timer: one shared counter of width $clog2(max(MSG_CYCLES, LOCKOUT_CYCLES, IDLE_CYCLES)+1).
  - Cleared on every state change and on every key_valid in ENTRY, UNLOCKED and NEW_ENTRY.
  - Expiry is tested as timer==limit-1; on expiry the transition fires on the next edge.
- Simultaneous key_valid and timer expiry: the key wins; the timer restarts.

Optional Feature:
PWD_MASK_EN: when defined, entered digits in ENTRY and NEW_ENTRY are displayed as 4'h8 (all segments lit) instead of their values; enables and count are unchanged. When undefined, actual digit values are shown. All other states are identical in both builds.

Test Plan:
- Reset, then keys 1,2,3,4,# (CODE_LEN=4) -> state_o 1 after first key, 2 then 4; unlocked=1 exactly 2 cycles after '#'; fail_cnt=0.
- Keys 1,2,3,5,# three times (MAX_TRIES=3) -> fail_cnt 1, 2 with FAIL/4'hE shown for MSG_CYCLES; third attempt enters LOCKOUT, alarm=1 for LOCKOUT_CYCLES with keys ignored; then IDLE with fail_cnt=0.
- Keys 1,2,3 then # -> CHECK mismatch, fail_cnt=1. Keys 1,2,3,4,5,# -> 5 ignored, unlocks.
- In UNLOCKED: C,9,8,7,#(ignored),6,#,* then 9,8,7,6,# -> code changes, relocks, unlocks with 9876; old code 1234 now fails.
- Enter 1,2 then idle for IDLE_CYCLES -> IDLE, digit_en=0. Key 5 at the expiry cycle -> stays in ENTRY, count=3.
- Reset asserted mid-LOCKOUT and mid-NEW_ENTRY -> next cycle all outputs 0 and code=DEFAULT_CODE. With PWD_MASK_EN, entering 7 shows nibble 8 at digit 0, digit_en=0001.
